// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Port that issued an in-flight transaction.
    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // One response-tracking entry: who gets the response and which 32-bit lane.
    typedef struct packed {
        owner_e     owner;
        logic [1:0] lane;
    } trk_entry_t;

    localparam int unsigned LINE_BYTES = 16;

endpackage

// File: rtl/mem_arb_tracker.sv
// In-order FIFO recording owner and lane of each accepted memory transaction.
module mem_arb_tracker
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  trk_entry_t push_data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output trk_entry_t head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    trk_entry_t       store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign head_o  = store_q[rd_ptr_q];

    // Pointer wrap and occupancy update; simultaneous push and pop keep count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while the slot is empty.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 128-bit memory between fetch and data ports.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 22,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [127:0]          instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [15:0]           mem_be_o,
    output logic [127:0]          mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [127:0]          mem_rdata_i,
    output logic                  err_o
);

    owner_e     sel;
    owner_e     prio_q, prio_d;
    logic       err_q, err_d;
    logic       full, empty, accept, pop;
    trk_entry_t head, push_entry;

    // Byte-offset bits below the line/lane granularity do not reach the memory.
    logic unused_addr;
    assign unused_addr = ^{instr_addr_i[3:0], data_addr_i[1:0]};

    assign mem_req_o   = (instr_req_i | data_req_i) & ~full & ~rst_i;
    assign accept      = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = accept & (sel == OWN_INSTR);
    assign data_gnt_o  = accept & (sel == OWN_DATA);
    assign mem_wdata_o = {4{data_wdata_i}};

    // Pick the requesting port; prio breaks ties.
    always_comb begin
        if (instr_req_i && data_req_i) begin
            sel = prio_q;
        end else if (data_req_i) begin
            sel = OWN_DATA;
        end else begin
            sel = OWN_INSTR;
        end
    end

    // Steer address, write enable, byte enables and lane from the selected port.
    always_comb begin
        push_entry.owner = sel;
        if (sel == OWN_DATA) begin
            mem_addr_o      = {data_addr_i[ADDR_WIDTH-1:4], 4'h0};
            mem_we_o        = data_we_i;
            mem_be_o        = 16'(data_be_i) << {data_addr_i[3:2], 2'b00};
            push_entry.lane = data_addr_i[3:2];
        end else begin
            mem_addr_o      = {instr_addr_i[ADDR_WIDTH-1:4], 4'h0};
            mem_we_o        = 1'b0;
            mem_be_o        = 16'hFFFF;
            push_entry.lane = 2'b00;
        end
    end

    // Route each response to the head entry's owner; a stray response is dropped.
    always_comb begin
        pop            = mem_rvalid_i & ~empty & ~rst_i;
        instr_rvalid_o = pop & (head.owner == OWN_INSTR);
        data_rvalid_o  = pop & (head.owner == OWN_DATA);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i[{head.lane, 5'b00000} +: 32];
    end

    // Priority passes to the port that was not just served; error is sticky.
    always_comb begin
        prio_d = prio_q;
        if (accept) begin
            prio_d = (sel == OWN_DATA) ? OWN_INSTR : OWN_DATA;
        end
        err_d = err_q | (mem_rvalid_i & empty);
    end

    // Arbiter state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= OWN_DATA;
            err_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q & ~rst_i;

    mem_arb_tracker #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_tracker (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (accept),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .head_o     (head)
    );

endmodule
